// File: rtl/axis_frame_arbiter_if.sv
// Bundle of the per-port AXI-Stream inputs, the arbitrated output stream and
// the grant/frame status of axis_frame_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives the input ports and consumes the output stream.
interface axis_frame_arbiter_if #(
   parameter int S_COUNT    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int USER_WIDTH = 1
);
   localparam int IDX_W = $clog2(S_COUNT);

   logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata;
   logic [S_COUNT-1:0]            s_axis_tvalid;
   logic [S_COUNT-1:0]            s_axis_tready;
   logic [S_COUNT-1:0]            s_axis_tlast;
   logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser;

   logic [DATA_WIDTH-1:0]         m_axis_tdata;
   logic                          m_axis_tvalid;
   logic                          m_axis_tready;
   logic                          m_axis_tlast;
   logic [USER_WIDTH-1:0]         m_axis_tuser;

   logic                          grant_valid;
   logic [IDX_W-1:0]              grant_index;
   logic                          frame_done;

   modport slave (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
      output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
      output grant_valid, grant_index, frame_done
   );

   modport master (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
      input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
      input  grant_valid, grant_index, frame_done
   );
endinterface

// File: rtl/axis_frame_arbiter.sv
// Frame-granular round-robin arbiter: S_COUNT AXI-Stream inputs share one
// registered output stream. A port keeps the grant from its first beat until
// its tlast beat is accepted; the next arbitration happens in a single IDLE
// bubble cycle, searching from the port after the last one served.
module axis_frame_arbiter #(
   parameter int S_COUNT    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int USER_WIDTH = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   axis_frame_arbiter_if.slave  arb_if
);
   localparam int IDX_W = $clog2(S_COUNT);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   // Control state
   state_e                state_q,       state_d;
   logic [IDX_W-1:0]      last_grant_q,  last_grant_d;
   logic [IDX_W-1:0]      grant_index_q, grant_index_d;
   logic                  grant_valid_q, grant_valid_d;
   logic                  frame_done_q,  frame_done_d;

   // Output stage
   logic                  m_tvalid_q, m_tvalid_d;
   logic [DATA_WIDTH-1:0] m_tdata_q,  m_tdata_d;
   logic                  m_tlast_q,  m_tlast_d;
   logic [USER_WIDTH-1:0] m_tuser_q,  m_tuser_d;

   // Combinational helpers
   logic [IDX_W-1:0]      rr_cand_s;
   logic [IDX_W-1:0]      rr_pick_s;
   logic                  rr_found_s;
   logic                  out_ready_s;
   logic                  beat_accept_s;
   logic                  sel_tlast_s;
   logic [DATA_WIDTH-1:0] sel_tdata_s;
   logic [USER_WIDTH-1:0] sel_tuser_s;
   logic [S_COUNT-1:0]    s_tready_s;

   // Granted port's beat, routed towards the output register
   assign sel_tdata_s = arb_if.s_axis_tdata[grant_index_q*DATA_WIDTH +: DATA_WIDTH];
   assign sel_tuser_s = arb_if.s_axis_tuser[grant_index_q*USER_WIDTH +: USER_WIDTH];
   assign sel_tlast_s = arb_if.s_axis_tlast[grant_index_q];

   // The output register can take a beat when it is empty or being drained
   assign out_ready_s   = !m_tvalid_q || arb_if.m_axis_tready;
   assign beat_accept_s = (state_q == ST_BUSY) && arb_if.s_axis_tvalid[grant_index_q]
                          && out_ready_s;

   // Round-robin search: first valid port starting after the last grant
   always_comb begin
      rr_pick_s  = '0;
      rr_found_s = 1'b0;
      rr_cand_s  = '0;
      for (int off = 1; off <= S_COUNT; off++) begin
         rr_cand_s = IDX_W'((int'(last_grant_q) + off) % S_COUNT);
         if (!rr_found_s && arb_if.s_axis_tvalid[rr_cand_s]) begin
            rr_found_s = 1'b1;
            rr_pick_s  = rr_cand_s;
         end else begin
            rr_found_s = rr_found_s;
         end
      end
   end

   // Only the granted port sees tready, and only while the output can take data
   always_comb begin
      s_tready_s = '0;
      if (state_q == ST_BUSY) begin
         s_tready_s[grant_index_q] = out_ready_s;
      end else begin
         s_tready_s = '0;
      end
   end

   // Arbitration FSM next state: grant in IDLE, release on accepted tlast
   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      grant_index_d = grant_index_q;
      grant_valid_d = grant_valid_q;
      frame_done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rr_found_s) begin
               state_d       = ST_BUSY;
               grant_index_d = rr_pick_s;
               grant_valid_d = 1'b1;
            end else begin
               state_d       = ST_IDLE;
               grant_valid_d = 1'b0;
            end
         end
         ST_BUSY: begin
            if (beat_accept_s && sel_tlast_s) begin
               state_d       = ST_IDLE;
               grant_valid_d = 1'b0;
               last_grant_d  = grant_index_q;
               frame_done_d  = 1'b1;
            end else begin
               state_d       = ST_BUSY;
               grant_valid_d = 1'b1;
            end
         end
         default: begin
            state_d       = ST_IDLE;
            grant_valid_d = 1'b0;
         end
      endcase
   end

   // Output stage next state: load on accept, drain on downstream ready
   always_comb begin
      m_tvalid_d = m_tvalid_q;
      m_tdata_d  = m_tdata_q;
      m_tlast_d  = m_tlast_q;
      m_tuser_d  = m_tuser_q;
      if (beat_accept_s) begin
         m_tvalid_d = 1'b1;
         m_tdata_d  = sel_tdata_s;
         m_tlast_d  = sel_tlast_s;
         m_tuser_d  = sel_tuser_s;
      end else if (arb_if.m_axis_tready) begin
         m_tvalid_d = 1'b0;
      end else begin
         m_tvalid_d = m_tvalid_q;
      end
   end

   // Control registers with synchronous active-low reset; port 0 first after reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         last_grant_q  <= IDX_W'(S_COUNT - 1);
         grant_index_q <= '0;
         grant_valid_q <= 1'b0;
         frame_done_q  <= 1'b0;
         m_tvalid_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         grant_index_q <= grant_index_d;
         grant_valid_q <= grant_valid_d;
         frame_done_q  <= frame_done_d;
         m_tvalid_q    <= m_tvalid_d;
      end
   end

   // Output payload registers; contents are qualified by m_tvalid_q only
   always_ff @(posedge clk) begin
      m_tdata_q <= m_tdata_d;
      m_tlast_q <= m_tlast_d;
      m_tuser_q <= m_tuser_d;
   end

   assign arb_if.s_axis_tready = s_tready_s;
   assign arb_if.m_axis_tdata  = m_tdata_q;
   assign arb_if.m_axis_tvalid = m_tvalid_q;
   assign arb_if.m_axis_tlast  = m_tlast_q;
   assign arb_if.m_axis_tuser  = m_tuser_q;
   assign arb_if.grant_valid   = grant_valid_q;
   assign arb_if.grant_index   = grant_index_q;
   assign arb_if.frame_done    = frame_done_q;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Directed bench for axis_frame_arbiter: per-port frame sources, an output
// transfer log and per-cycle tready/grant checks, all in one initial block.
module tb_axis_frame_arbiter;
   localparam int S  = 4;
   localparam int DW = 8;
   localparam int UW = 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   axis_frame_arbiter_if #(.S_COUNT(S), .DATA_WIDTH(DW), .USER_WIDTH(UW)) bus ();

   axis_frame_arbiter #(.S_COUNT(S), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
      .clk    (clk),
      .rst    (rst),
      .arb_if (bus)
   );

   int errors = 0;
   int checks = 0;

   // Source model state per port
   int         beat [S];
   int         len  [S];
   int         left [S];
   int         fcnt [S];
   logic [S-1:0] active;
   logic [S-1:0] gap_mask;
   logic [S-1:0] acc;

   // Observation
   logic [9:0]  out_log[$];
   logic [9:0]  exp_q[$];
   logic [1:0]  grant_log[$];
   logic [1:0]  grant_exp[$];
   logic        prev_gv;
   logic [1:0]  prev_gi;
   int          fd_count;
   logic [31:0] vtrace;
   logic [31:0] ftrace;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] ev(input logic last, input logic [7:0] data);
      return {last, data[6], data};
   endfunction

   task automatic drive();
      for (int p = 0; p < S; p++) begin
         bus.s_axis_tvalid[p]         = active[p] && !gap_mask[p];
         bus.s_axis_tdata[p*DW +: DW] = {2'(p), 2'(fcnt[p]), 4'(beat[p])};
         bus.s_axis_tlast[p]          = (beat[p] == len[p]);
         bus.s_axis_tuser[p]          = 1'(p % 2);
      end
   endtask

   task automatic reset_sources();
      for (int p = 0; p < S; p++) begin
         beat[p] = 1; len[p] = 1; left[p] = 0; fcnt[p] = 0;
      end
      active   = '0;
      gap_mask = '0;
      drive();
   endtask

   task automatic start(input int p, input int nframes, input int n);
      active[p] = 1'b1;
      left[p]   = nframes;
      len[p]    = n;
      beat[p]   = 1;
      drive();
   endtask

   task automatic clear_obs();
      out_log.delete();
      grant_log.delete();
      fd_count = 0;
      vtrace   = '0;
      ftrace   = '0;
   endtask

   // One clock: observe at the falling edge, then advance sources after the rising edge
   task automatic tick();
      @(negedge clk);
      acc = bus.s_axis_tvalid & bus.s_axis_tready;
      if (bus.m_axis_tvalid && bus.m_axis_tready)
         out_log.push_back({bus.m_axis_tlast, bus.m_axis_tuser, bus.m_axis_tdata});
      if (bus.grant_valid && !prev_gv)
         grant_log.push_back(bus.grant_index);
      if (bus.frame_done)
         fd_count++;
      chk("tready_onehot0", 32'($onehot0(bus.s_axis_tready)), 32'd1);
      if (prev_gv && bus.grant_valid)
         chk("grant_stable", 32'(bus.grant_index), 32'(prev_gi));
      prev_gv = bus.grant_valid;
      prev_gi = bus.grant_index;
      vtrace  = {vtrace[30:0], bus.m_axis_tvalid};
      ftrace  = {ftrace[30:0], bus.frame_done};
      @(posedge clk);
      #1;
      for (int p = 0; p < S; p++) begin
         if (acc[p] && active[p]) begin
            if (beat[p] == len[p]) begin
               fcnt[p]++;
               left[p]--;
               beat[p] = 1;
               if (left[p] == 0) active[p] = 1'b0;
            end else begin
               beat[p]++;
            end
         end
      end
      drive();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check_log(input string tag);
      chk({tag, "_len"}, 32'(out_log.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < out_log.size()) chk(tag, 32'(out_log[i]), 32'(exp_q[i]));
      end
   endtask

   task automatic check_grants(input string tag);
      chk({tag, "_len"}, 32'(grant_log.size()), 32'(grant_exp.size()));
      for (int i = 0; i < grant_exp.size(); i++) begin
         if (i < grant_log.size()) chk(tag, 32'(grant_log[i]), 32'(grant_exp[i]));
      end
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_m_tvalid"}, 32'(bus.m_axis_tvalid), 32'd0);
      chk({tag, "_grant_valid"}, 32'(bus.grant_valid), 32'd0);
      chk({tag, "_grant_index"}, 32'(bus.grant_index), 32'd0);
      chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
      chk({tag, "_tready"}, 32'(bus.s_axis_tready), 32'd0);
   endtask

   initial begin
      bus.m_axis_tready = 1'b1;
      prev_gv = 1'b0;
      prev_gi = 2'd0;
      reset_sources();
      clear_obs();

      // Reset, then ports 0 and 2 each send one 3-beat frame
      rst = 1'b0;
      ticks(2);
      check_reset_state("rst0");
      rst = 1'b1;
      clear_obs();
      start(0, 1, 3);
      start(2, 1, 3);
      ticks(9);
      chk("a_valid_trace", 32'(vtrace[8:0]), 32'(9'b0_0111_0111));
      chk("a_done_trace", 32'(ftrace[8:0]), 32'(9'b0_0001_0001));
      exp_q = '{ev(1'b0, 8'h01), ev(1'b0, 8'h02), ev(1'b1, 8'h03),
                ev(1'b0, 8'h81), ev(1'b0, 8'h82), ev(1'b1, 8'h83)};
      check_log("a_out");
      grant_exp = '{2'd0, 2'd2};
      check_grants("a_grant");
      chk("a_frame_done_cnt", 32'(fd_count), 32'd2);

      // Reset again, then all four ports continuously valid with 1-beat frames
      rst = 1'b0;
      tick();
      check_reset_state("rst1");
      rst = 1'b1;
      reset_sources();
      clear_obs();
      for (int p = 0; p < S; p++) start(p, 2, 1);
      ticks(18);
      chk("b_valid_trace", 32'(vtrace[17:0]), 32'(18'h0AAAA));
      exp_q = '{ev(1'b1, 8'h01), ev(1'b1, 8'h41), ev(1'b1, 8'h81), ev(1'b1, 8'hC1),
                ev(1'b1, 8'h11), ev(1'b1, 8'h51), ev(1'b1, 8'h91), ev(1'b1, 8'hD1)};
      check_log("b_out");
      grant_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
      check_grants("b_grant");
      chk("b_frame_done_cnt", 32'(fd_count), 32'd8);

      // Port 1, 4-beat frame, downstream stalls for 5 cycles after beat 2
      reset_sources();
      clear_obs();
      start(1, 1, 4);
      ticks(3);
      chk("c_beat2_data", 32'(bus.m_axis_tdata), 32'h42);
      bus.m_axis_tready = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("c_hold_valid", 32'(bus.m_axis_tvalid), 32'd1);
         chk("c_hold_data", 32'(bus.m_axis_tdata), 32'h42);
         chk("c_hold_tready1", 32'(bus.s_axis_tready[1]), 32'd0);
         tick();
      end
      bus.m_axis_tready = 1'b1;
      ticks(4);
      exp_q = '{ev(1'b0, 8'h41), ev(1'b0, 8'h42), ev(1'b0, 8'h43), ev(1'b1, 8'h44)};
      check_log("c_out");
      chk("c_frame_done_cnt", 32'(fd_count), 32'd1);

      // Port 3 mid-frame while port 0 becomes valid; port 0 wins next by wrap
      reset_sources();
      clear_obs();
      start(3, 1, 3);
      tick();
      start(0, 1, 2);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("d_tready0_blocked", 32'(bus.s_axis_tready[0]), 32'd0);
         chk("d_grant3", 32'(bus.grant_index), 32'd3);
         tick();
      end
      chk("d_bubble_gv", 32'(bus.grant_valid), 32'd0);
      chk("d_bubble_tready", 32'(bus.s_axis_tready), 32'd0);
      tick();
      chk("d_wrap_gv", 32'(bus.grant_valid), 32'd1);
      chk("d_wrap_gi", 32'(bus.grant_index), 32'd0);
      chk("d_wrap_tready", 32'(bus.s_axis_tready), 32'h1);
      ticks(4);
      exp_q = '{ev(1'b0, 8'hC1), ev(1'b0, 8'hC2), ev(1'b1, 8'hC3),
                ev(1'b0, 8'h01), ev(1'b1, 8'h02)};
      check_log("d_out");

      // Reset after beat 2 of a 5-beat frame from port 1
      reset_sources();
      clear_obs();
      start(1, 1, 5);
      ticks(3);
      rst = 1'b0;
      tick();
      chk("e_rst_m_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
      chk("e_rst_gv", 32'(bus.grant_valid), 32'd0);
      chk("e_rst_tready", 32'(bus.s_axis_tready), 32'd0);
      reset_sources();
      tick();
      rst = 1'b1;
      start(0, 1, 1);
      start(1, 1, 1);
      start(3, 1, 1);
      tick();
      chk("e_prio_gv", 32'(bus.grant_valid), 32'd1);
      chk("e_prio_gi", 32'(bus.grant_index), 32'd0);
      ticks(2);
      exp_q = '{ev(1'b0, 8'h41), ev(1'b0, 8'h42), ev(1'b1, 8'h01)};
      check_log("e_out");
      ticks(8);

      // Granted port 2 drops tvalid mid-frame while port 3 waits
      reset_sources();
      clear_obs();
      start(2, 1, 3);
      start(3, 1, 1);
      ticks(2);
      gap_mask[2] = 1'b1;
      drive();
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("f_gap_gv", 32'(bus.grant_valid), 32'd1);
         chk("f_gap_gi", 32'(bus.grant_index), 32'd2);
         chk("f_gap_tready3", 32'(bus.s_axis_tready[3]), 32'd0);
         tick();
      end
      gap_mask[2] = 1'b0;
      drive();
      ticks(8);
      exp_q = '{ev(1'b0, 8'h81), ev(1'b0, 8'h82), ev(1'b1, 8'h83), ev(1'b1, 8'hC1)};
      check_log("f_out");
      grant_exp = '{2'd2, 2'd3};
      check_grants("f_grant");
      chk("f_frame_done_cnt", 32'(fd_count), 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axis_frame_arbiter.md
AXIS_FRAME_ARBITER -- requirements
Module: axis_frame_arbiter

Interface
REQ-001 Parameter S_COUNT, default 4: number of AXI-Stream input ports; legal range 2..16.
REQ-002 Parameter DATA_WIDTH, default 8: tdata width per port.
REQ-003 Parameter USER_WIDTH, default 1: tuser width per port.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 rst  input  1  reset; synchronous, active-low.
REQ-006 s_axis_tdata  input  S_COUNT*DATA_WIDTH  per-port data; port i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 s_axis_tvalid  input  S_COUNT  per-port valid.
REQ-008 s_axis_tready  output  S_COUNT  per-port ready.
REQ-009 s_axis_tlast  input  S_COUNT  per-port end of frame.
REQ-010 s_axis_tuser  input  S_COUNT*USER_WIDTH  per-port user sideband.
REQ-011 m_axis_tdata  output  DATA_WIDTH  arbitrated output data, towards the downstream FIFO.
REQ-012 m_axis_tvalid, m_axis_tready, m_axis_tlast  output, input, output  1 each  output handshake and end of frame.
REQ-013 m_axis_tuser  output  USER_WIDTH  output user sideband.
REQ-014 grant_valid  output  1  high while a port holds the grant.
REQ-015 grant_index  output  $clog2(S_COUNT)  index of the granted port; meaningful only when grant_valid is high.
REQ-016 frame_done  output  1  one-cycle pulse when the last beat of a frame is accepted from an input.

Function
REQ-017 The FSM SHALL have two states: IDLE and BUSY.
REQ-018 In IDLE with any s_axis_tvalid bit set, the block SHALL select a port round-robin and enter BUSY on the next clock.
- Search starts at (last_grant+1) mod S_COUNT and takes the first port with tvalid high.
- grant_valid=1 and grant_index=the selected port.
REQ-019 In IDLE with no tvalid set, the state SHALL stay IDLE and last_grant SHALL hold.
REQ-020 In BUSY, s_axis_tready[grant_index] SHALL equal (!m_axis_tvalid || m_axis_tready); all other tready bits SHALL be 0.
- In IDLE, all tready bits SHALL be 0.
REQ-021 On an accepted input beat, the block SHALL register tdata/tlast/tuser into the output stage and set m_axis_tvalid on the next clock.
- Input-to-output latency is 1 cycle.
- Full throughput of 1 beat/cycle while m_axis_tready stays high.
REQ-022 The output register SHALL hold data and tvalid stable while m_axis_tvalid=1 and m_axis_tready=0.
- m_axis_tvalid SHALL clear after a transfer with no new input beat.
REQ-023 When an input beat with tlast=1 is accepted in BUSY:
- frame_done SHALL pulse on the next cycle;
- last_grant SHALL take grant_index;
- the state SHALL return to IDLE, giving exactly one arbitration bubble cycle between frames.
REQ-024 The grant SHALL never change in mid-frame, whatever the other ports' tvalid does.
REQ-025 A granted port deasserting tvalid in mid-frame SHALL keep the grant (no timeout).
REQ-026 Wrap-around: after a grant to port S_COUNT-1, the search SHALL start at port 0.
REQ-027 A single-beat frame (tlast on the first beat) SHALL occupy BUSY for exactly one accepted beat.

Reset
REQ-028 While rst=0 at a clock edge, the block SHALL set:
- state=IDLE, last_grant=S_COUNT-1 (so port 0 has first priority), m_axis_tvalid=0, grant_valid=0, grant_index=0, frame_done=0;
- all s_axis_tready bits 0.
REQ-029 Reset asserted in mid-frame SHALL abandon the frame with no further output beats; data registers need not be reset.

Verification
REQ-030 Reset, then ports 0 and 2 both assert tvalid with 3-beat frames, m_axis_tready=1 -> port 0 frame out (beats 1..3), one bubble, then port 2 frame; frame_done pulses twice.
REQ-031 All four ports continuously valid with 1-beat frames -> grant order 0,1,2,3,0 and output beat every second cycle.
REQ-032 Port 1 granted, 4-beat frame, m_axis_tready low for 5 cycles after beat 2 -> beat 2 held stable, s_axis_tready[1]=0; resumes with no loss or duplication.
REQ-033 Port 3 mid-frame, port 0 asserts tvalid -> port 0 tready stays 0 until port 3 tlast accepted; then port 0 granted (wrap).
REQ-034 rst driven low after beat 2 of a 5-beat frame -> next cycle m_axis_tvalid=0, grant_valid=0, all tready 0; after release, port 0 has priority.
REQ-035 A bench assertion SHALL flag any cycle where more than one s_axis_tready bit is high, or where grant_index changes while in BUSY.
